// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper that captures and checks a DUT truth table
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int M_OUT = 1,
  parameter int DWELL = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N_IN-1:0]              pattern,
  input  logic [M_OUT-1:0]             dut_f,
  input  logic [M_OUT*(2**N_IN)-1:0]   expected,
  output logic                         busy,
  output logic                         done,
  output logic [M_OUT*(2**N_IN)-1:0]   table_out,
  output logic [N_IN:0]                mismatch_cnt,
  output logic [N_IN-1:0]              first_fail_idx,
  output logic                         first_fail_valid,
  output logic                         pass
);

  localparam int NP = 2**N_IN;
  localparam int TW = M_OUT * NP;
  localparam int IW = (TW > 1) ? $clog2(TW) : 1;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N_IN-1:0] PAT_LAST = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t             state_q;
  logic [N_IN-1:0]    pattern_q;
  logic [7:0]         dwell_q;
  logic               busy_q;
  logic               done_q;
  logic [TW-1:0]      table_q;
  logic [TW-1:0]      table_d;
  logic [N_IN:0]      mm_q;
  logic [N_IN:0]      mm_d;
  logic [N_IN-1:0]    ffi_q;
  logic               ffv_q;
  logic               pass_q;
  logic [M_OUT-1:0]   exp_bits;
  logic [IW-1:0]      idx;
  logic               sample_miss;

  assign pattern          = pattern_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign table_out        = table_q;
  assign mismatch_cnt     = mm_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
  assign pass             = pass_q;

  // Output j of pattern p lives at bit j*NP+p in both the golden and captured tables.
  always_comb begin
    idx      = '0;
    exp_bits = '0;
    table_d  = table_q;
    for (int j = 0; j < M_OUT; j++) begin
      idx          = IW'(j * NP) + IW'(pattern_q);
      exp_bits[j]  = expected[idx];
      table_d[idx] = dut_f[j];
    end
    sample_miss = (exp_bits != dut_f);
    mm_d        = sample_miss ? (N_IN+1)'(mm_q + 1) : mm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      dwell_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      table_q   <= '0;
      mm_q      <= '0;
      ffi_q     <= '0;
      ffv_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= DRIVE;
            busy_q    <= 1'b1;
            pattern_q <= '0;
            dwell_q   <= '0;
            table_q   <= '0;
            mm_q      <= '0;
            ffi_q     <= '0;
            ffv_q     <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        DRIVE: begin
          if (dwell_q == DWELL_LAST) begin
            table_q <= table_d;
            mm_q    <= mm_d;
            dwell_q <= '0;
            if (sample_miss && !ffv_q) begin
              ffi_q <= pattern_q;
              ffv_q <= 1'b1;
            end
            // Last pattern stays on the bus; pass must already see the final compare.
            if (pattern_q == PAT_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mm_d == '0);
            end else begin
              pattern_q <= N_IN'(pattern_q + 1);
            end
          end else begin
            dwell_q <= 8'(dwell_q + 1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper against a table-level model
`timescale 1ns/1ps
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    int          mm;
    int          ffi;
    bit          ffv;
    bit          pass;
    int          done_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] done_v;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t last_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 4 inputs, 1 output, dwell 4
  int          fsel_a = 0;
  logic [15:0] rt_a = '0;
  logic [15:0] exp_a = '0;
  logic [3:0]  pattern_a;
  logic [0:0]  dut_f_a;
  logic        busy_a, done_a, ffv_a, pass_a;
  logic [15:0] table_a;
  logic [4:0]  mm_a;
  logic [3:0]  ffi_a;
  assign dut_f_a = (fsel_a == 1) ? rt_a[pattern_a] : (pattern_a[3] & pattern_a[2]);

  truth_table_sweeper #(.N_IN(4), .M_OUT(1), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .pattern(pattern_a), .dut_f(dut_f_a),
    .expected(exp_a), .busy(busy_a), .done(done_a), .table_out(table_a),
    .mismatch_cnt(mm_a), .first_fail_idx(ffi_a), .first_fail_valid(ffv_a), .pass(pass_a)
  );

  // Instance B: 2 inputs, 1 output, dwell 1, XOR DUT
  logic [3:0] exp_b = '0;
  logic [1:0] pattern_b;
  logic [0:0] dut_f_b;
  logic       busy_b, done_b, ffv_b, pass_b;
  logic [3:0] table_b;
  logic [2:0] mm_b;
  logic [1:0] ffi_b;
  assign dut_f_b = ^pattern_b;

  truth_table_sweeper #(.N_IN(2), .M_OUT(1), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .pattern(pattern_b), .dut_f(dut_f_b),
    .expected(exp_b), .busy(busy_b), .done(done_b), .table_out(table_b),
    .mismatch_cnt(mm_b), .first_fail_idx(ffi_b), .first_fail_valid(ffv_b), .pass(pass_b)
  );

  // Instance C: 2 inputs, 2 outputs {AND, OR}, dwell 1
  logic [7:0] exp_c = '0;
  logic [1:0] pattern_c;
  logic [1:0] dut_f_c;
  logic       busy_c, done_c, ffv_c, pass_c;
  logic [7:0] table_c;
  logic [2:0] mm_c;
  logic [1:0] ffi_c;
  assign dut_f_c = {&pattern_c, |pattern_c};

  truth_table_sweeper #(.N_IN(2), .M_OUT(2), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .pattern(pattern_c), .dut_f(dut_f_c),
    .expected(exp_c), .busy(busy_c), .done(done_c), .table_out(table_c),
    .mismatch_cnt(mm_c), .first_fail_idx(ffi_c), .first_fail_valid(ffv_c), .pass(pass_c)
  );

  assign done_v = {done_c, done_b, done_a};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: evaluate the DUT function on every pattern and grade it against the golden table.
  function automatic exp_t model(input int n, input int m, input int fsel,
                                 input logic [15:0] rt, input logic [15:0] ev);
    exp_t e;
    int   np;
    bit   diff, f;
    np = 1 << n;
    e.tbl = '0; e.mm = 0; e.ffi = 0; e.ffv = 0; e.done_at = 0;
    for (int p = 0; p < np; p++) begin
      diff = 0;
      for (int j = 0; j < m; j++) begin
        case (fsel)
          0:       f = (p >= 12);
          1:       f = rt[p];
          2:       f = (($countones(p) % 2) == 1);
          default: f = (j == 1) ? (p == np - 1) : (p != 0);
        endcase
        e.tbl[j*np+p] = f;
        if (f != ev[j*np+p]) diff = 1;
      end
      if (diff) begin
        e.mm++;
        if (!e.ffv) begin e.ffi = p; e.ffv = 1; end
      end
    end
    e.pass = (e.mm == 0);
    return e;
  endfunction

  task automatic cmp_res(input string nm, input exp_t e, input logic [31:0] tbl, input logic [31:0] mm,
                         input logic [31:0] ffi, input logic [31:0] ffv, input logic [31:0] ps,
                         input logic [31:0] bsy);
    chk({nm, "_table"}, tbl, e.tbl);
    chk({nm, "_mismatch_cnt"}, mm, e.mm);
    chk({nm, "_first_fail_idx"}, ffi, e.ffi);
    chk({nm, "_first_fail_valid"}, ffv, e.ffv);
    chk({nm, "_pass"}, ps, e.pass);
    chk({nm, "_done_cycle"}, cyc, e.done_at);
    chk({nm, "_busy_at_done"}, bsy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_done", qa.size(), 1);
      else begin e = qa.pop_front(); cmp_res("a", e, table_a, mm_a, ffi_a, ffv_a, pass_a, busy_a); last_a = e; end
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_done", qb.size(), 1);
      else begin e = qb.pop_front(); cmp_res("b", e, table_b, mm_b, ffi_b, ffv_b, pass_b, busy_b); end
    end
    if (done_c === 1'b1) begin
      if (qc.size() == 0) chk("c_unexpected_done", qc.size(), 1);
      else begin e = qc.pop_front(); cmp_res("c", e, table_c, mm_c, ffi_c, ffv_c, pass_c, busy_c); end
    end
  end

  task automatic start_sweep(input int inst, input int fsel, input logic [15:0] rt, input logic [15:0] ev);
    exp_t e;
    int n, m, d;
    n = 2; m = 1; d = 1;
    case (inst)
      0: begin n = 4; fsel_a = fsel; rt_a = rt; exp_a = ev; d = 4; end
      1: exp_b = ev[3:0];
      default: begin m = 2; exp_c = ev[7:0]; end
    endcase
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    e = model(n, m, fsel, rt, ev);
    e.done_at = cyc + (1 << n) * d;
    case (inst)
      0: begin qa.push_back(e); chk("a_busy_rise", busy_a, 1); end
      1: begin qb.push_back(e); chk("b_busy_rise", busy_b, 1); end
      default: begin qc.push_back(e); chk("c_busy_rise", busy_c, 1); end
    endcase
  endtask

  task automatic wait_done(input int inst, input int budget);
    int i;
    i = 0;
    while (done_v[inst] !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("done_seen_%0d", inst), done_v[inst], 1);
    @(negedge clk);
  endtask

  task automatic wait_pat_a(input int p, input int budget);
    int i;
    i = 0;
    while (pattern_a != p && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("a_reach_pattern", pattern_a, p);
  endtask

  task automatic hold_chk_a();
    repeat (3) @(negedge clk);
    chk("a_hold_table", table_a, last_a.tbl);
    chk("a_hold_mismatch_cnt", mm_a, last_a.mm);
    chk("a_hold_pass", pass_a, last_a.pass);
    chk("a_hold_ffv", ffv_a, last_a.ffv);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    chk("rst_pattern", pattern_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_table", table_a, 0);
    chk("rst_mismatch_cnt", mm_a, 0);
    chk("rst_first_fail_idx", ffi_a, 0);
    chk("rst_first_fail_valid", ffv_a, 0);
    chk("rst_pass", pass_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d required finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] rt, mask;
    do_reset(3);

    start_sweep(0, 0, 16'h0, 16'hF000);
    wait_done(0, 200);
    hold_chk_a();

    start_sweep(0, 0, 16'h0, 16'hF001);
    wait_done(0, 200);
    hold_chk_a();

    start_sweep(0, 0, 16'h0, 16'hF000);
    wait_pat_a(5, 100);
    do_reset(1);
    repeat (4) @(negedge clk);
    chk("a_idle_after_rst", busy_a, 0);

    start_sweep(0, 0, 16'h0, 16'hF000);
    wait_done(0, 200);

    start_sweep(0, 0, 16'h0, 16'hF000);
    wait_pat_a(9, 100);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 200);
    hold_chk_a();

    for (int k = 0; k < 6; k++) begin
      rt = 16'($urandom);
      mask = (k == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
      start_sweep(0, 1, rt, rt ^ mask);
      wait_done(0, 200);
      hold_chk_a();
    end

    start_sweep(1, 2, 16'h0, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      chk("b_pattern_seq", pattern_b, i);
      @(posedge clk);
      #1;
    end
    wait_done(1, 20);
    start_sweep(1, 2, 16'h0, 16'h000E);
    wait_done(1, 20);

    start_sweep(2, 3, 16'h0, 16'h008E);
    wait_done(2, 20);
    for (int k = 0; k < 3; k++) begin
      start_sweep(2, 3, 16'h0, 16'($urandom & 32'hFF));
      wait_done(2, 20);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
